// File: rtl/reg_master_arbiter.sv
// Round-robin arbiter sharing one register slave port among NUM_MASTERS requesters.
// One transaction in flight at a time; a silent slave is answered with 0xdeadbeef after TIMEOUT cycles.
module reg_master_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 18,
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT     = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MASTERS-1:0]            m_reg_req,
    input  logic [NUM_MASTERS-1:0]            m_reg_rd_wr_L,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_reg_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_reg_wr_data,
    output logic [NUM_MASTERS-1:0]            m_reg_ack,
    output logic [DATA_WIDTH-1:0]             m_reg_rd_data,
    output logic                              s_reg_req,
    output logic                              s_reg_rd_wr_L,
    output logic [ADDR_WIDTH-1:0]             s_reg_addr,
    output logic [DATA_WIDTH-1:0]             s_reg_wr_data,
    input  logic                              s_reg_ack,
    input  logic [DATA_WIDTH-1:0]             s_reg_rd_data,
    output logic                              timeout_pulse
);
    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [DATA_WIDTH-1:0] DEAD = DATA_WIDTH'(32'hdeadbeef);
    localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, GRANT, DROP} state_t;

    state_t                 state_q, state_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [GW-1:0]          last_q, last_d;
    logic [7:0]             timer_q, timer_d;
    logic                   s_req_q, s_req_d;
    logic                   s_rw_q, s_rw_d;
    logic [ADDR_WIDTH-1:0]  s_addr_q, s_addr_d;
    logic [DATA_WIDTH-1:0]  s_wdata_q, s_wdata_d;
    logic [NUM_MASTERS-1:0] m_ack_q, m_ack_d;
    logic [DATA_WIDTH-1:0]  m_rdata_q, m_rdata_d;
    logic                   to_q, to_d;

    // Round-robin pick: scanning downward lets the nearest requester after last_q win.
    logic [GW-1:0] sel;
    logic [GW:0]   cand;
    always_comb begin
        sel  = last_q;
        cand = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            cand = {1'b0, last_q} + (GW+1)'(k);
            if (cand >= (GW+1)'(NUM_MASTERS))
                cand = cand - (GW+1)'(NUM_MASTERS);
            if (m_reg_req[cand[GW-1:0]])
                sel = cand[GW-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        timer_d   = timer_q;
        s_req_d   = s_req_q;
        s_rw_d    = s_rw_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        m_ack_d   = '0;
        m_rdata_d = m_rdata_q;
        to_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (|m_reg_req) begin
                    grant_d   = sel;
                    last_d    = sel;
                    timer_d   = '0;
                    s_req_d   = 1'b1;
                    s_rw_d    = m_reg_rd_wr_L[sel];
                    s_addr_d  = m_reg_addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
                    s_wdata_d = m_reg_wr_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                // A slave ack in the timeout cycle takes priority over the timeout.
                if (s_reg_ack) begin
                    m_rdata_d        = s_reg_rd_data;
                    m_ack_d[grant_q] = 1'b1;
                    s_req_d          = 1'b0;
                    state_d          = DROP;
                end else if (timer_q == TMAX) begin
                    m_rdata_d        = DEAD;
                    m_ack_d[grant_q] = 1'b1;
                    to_d             = 1'b1;
                    s_req_d          = 1'b0;
                    state_d          = DROP;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            DROP: begin
                if (!m_reg_req[grant_q] && !s_reg_ack) begin
                    timer_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= GW'(NUM_MASTERS - 1);
            timer_q   <= '0;
            s_req_q   <= 1'b0;
            s_rw_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            m_ack_q   <= '0;
            m_rdata_q <= '0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            timer_q   <= timer_d;
            s_req_q   <= s_req_d;
            s_rw_q    <= s_rw_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            m_ack_q   <= m_ack_d;
            m_rdata_q <= m_rdata_d;
            to_q      <= to_d;
        end
    end

    assign m_reg_ack     = m_ack_q;
    assign m_reg_rd_data = m_rdata_q;
    assign s_reg_req     = s_req_q;
    assign s_reg_rd_wr_L = s_rw_q;
    assign s_reg_addr    = s_addr_q;
    assign s_reg_wr_data = s_wdata_q;
    assign timeout_pulse = to_q;

endmodule

// File: tb/tb_reg_master_arbiter.sv
// Bench for reg_master_arbiter: vector table, hand-written corner sequences and
// randomized multi-master traffic against a transaction-level arbitration model.
module tb_reg_master_arbiter;
    localparam int N  = 2;
    localparam int AW = 18;
    localparam int DW = 32;
    localparam int TO = 16;
    localparam logic [DW-1:0] DEAD = 32'hdeadbeef;

    logic clk = 1'b0;
    logic reset;
    logic [N-1:0]    m_reg_req, m_reg_rd_wr_L, m_reg_ack;
    logic [N*AW-1:0] m_reg_addr;
    logic [N*DW-1:0] m_reg_wr_data;
    logic [DW-1:0]   m_reg_rd_data, s_reg_wr_data, s_reg_rd_data;
    logic [AW-1:0]   s_reg_addr;
    logic            s_reg_req, s_reg_rd_wr_L, s_reg_ack, timeout_pulse;

    logic            slv_ack, force_ack;
    logic [DW-1:0]   force_data;
    int              slv_lat;
    logic [AW-1:0]   cap_addr;
    logic            cap_rw;
    logic [DW-1:0]   cap_wd;
    int              n_chk = 0;
    int              n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
        return 32'h12345668 + DW'(a);
    endfunction

    assign s_reg_ack     = slv_ack | force_ack;
    assign s_reg_rd_data = force_ack ? force_data : rd_fn(s_reg_addr);

    reg_master_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .m_reg_req(m_reg_req), .m_reg_rd_wr_L(m_reg_rd_wr_L),
        .m_reg_addr(m_reg_addr), .m_reg_wr_data(m_reg_wr_data),
        .m_reg_ack(m_reg_ack), .m_reg_rd_data(m_reg_rd_data),
        .s_reg_req(s_reg_req), .s_reg_rd_wr_L(s_reg_rd_wr_L),
        .s_reg_addr(s_reg_addr), .s_reg_wr_data(s_reg_wr_data),
        .s_reg_ack(s_reg_ack), .s_reg_rd_data(s_reg_rd_data),
        .timeout_pulse(timeout_pulse)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Slave: acks slv_lat cycles after seeing s_reg_req (0 = never), checks field stability.
    initial begin
        int w;
        w = 0;
        slv_ack = 1'b0;
        forever begin
            tick();
            slv_ack = 1'b0;
            if (s_reg_req) begin
                w++;
                if (w == 1) begin
                    cap_addr = s_reg_addr;
                    cap_rw   = s_reg_rd_wr_L;
                    cap_wd   = s_reg_wr_data;
                end else begin
                    check("s_fields_stable", 64'({s_reg_addr, s_reg_rd_wr_L, s_reg_wr_data}),
                          64'({cap_addr, cap_rw, cap_wd}));
                end
                if (slv_lat != 0 && w == slv_lat + 1) slv_ack = 1'b1;
            end else begin
                w = 0;
            end
        end
    end

    task automatic set_m(input int i, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_reg_rd_wr_L[i]         = rw;
        m_reg_addr[i*AW +: AW]   = a;
        m_reg_wr_data[i*DW +: DW] = d;
    endtask

    task automatic wait_ack(output int who, output int cyc);
        who = -1;
        cyc = 0;
        while (who < 0 && cyc < 40) begin
            tick();
            cyc++;
            for (int i = 0; i < N; i++) if (m_reg_ack[i]) who = i;
        end
        check("ack_arrives", 64'(who >= 0), 64'd1);
        if (who >= 0) check("ack_onehot", 64'($countones(m_reg_ack)), 64'd1);
    endtask

    task automatic finish_txn(input int m);
        tick();
        check("ack_single_pulse", 64'(m_reg_ack), 64'd0);
        check("timeout_single", 64'(timeout_pulse), 64'd0);
        m_reg_req[m] = 1'b0;
        tick();
        tick();
    endtask

    // Arbitration rule from the spec, expressed over a request mask.
    function automatic int rr_pick(input logic [N-1:0] mask, input int last);
        for (int k = 1; k <= N; k++) if (mask[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    typedef struct {
        int            m;
        logic          rw;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            lat;
        int            exp_cyc;
        logic [DW-1:0] exp_rd;
        logic          exp_to;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int who, cyc, mdl_last, exp_w, exp_cyc, lat;
        logic [N-1:0]  mask;
        logic          rrw[N];
        logic [AW-1:0] ra[N];
        logic [DW-1:0] rd[N];

        tbl[0] = '{0, 1'b1, 18'h00010, 32'h0,        1,  3,  32'h12345678, 1'b0};
        tbl[1] = '{1, 1'b0, 18'h3ffff, 32'ha5a5a5a5, 4,  6,  32'h12385667, 1'b0};
        tbl[2] = '{0, 1'b1, 18'h00123, 32'h11112222, 15, 17, 32'h1234578b, 1'b0};
        tbl[3] = '{1, 1'b1, 18'h2aaaa, 32'h0,        0,  17, 32'hdeadbeef, 1'b1};
        tbl[4] = '{0, 1'b0, 18'h00001, 32'h0,        2,  4,  32'h12345669, 1'b0};

        reset = 1'b1; m_reg_req = '0; m_reg_rd_wr_L = '0; m_reg_addr = '0; m_reg_wr_data = '0;
        force_ack = 1'b0; force_data = '0; slv_lat = 1;
        tick(); tick();
        check("rst_s_req", 64'(s_reg_req), 64'd0);
        check("rst_m_ack", 64'(m_reg_ack), 64'd0);
        check("rst_timeout", 64'(timeout_pulse), 64'd0);
        check("rst_rd_data", 64'(m_reg_rd_data), 64'd0);
        check("rst_s_fields", 64'({s_reg_addr, s_reg_rd_wr_L, s_reg_wr_data}), 64'd0);
        reset = 1'b0;

        for (int r = 0; r < 5; r++) begin
            slv_lat = tbl[r].lat;
            set_m(tbl[r].m, tbl[r].rw, tbl[r].a, tbl[r].d);
            m_reg_req[tbl[r].m] = 1'b1;
            wait_ack(who, cyc);
            check("tbl_who", 64'(who), 64'(tbl[r].m));
            check("tbl_latency", 64'(cyc), 64'(tbl[r].exp_cyc));
            check("tbl_rd_data", 64'(m_reg_rd_data), 64'(tbl[r].exp_rd));
            check("tbl_timeout", 64'(timeout_pulse), 64'(tbl[r].exp_to));
            check("tbl_s_fields", 64'({cap_addr, cap_rw, cap_wd}), 64'({tbl[r].a, tbl[r].rw, tbl[r].d}));
            finish_txn(tbl[r].m);
        end

        // Timeout followed by a late slave ack while the arbiter waits in DROP.
        slv_lat = 0;
        set_m(0, 1'b1, 18'h00200, 32'h0);
        m_reg_req[0] = 1'b1;
        wait_ack(who, cyc);
        check("late_to_latency", 64'(cyc), 64'd17);
        check("late_to_data", 64'(m_reg_rd_data), 64'(DEAD));
        check("late_to_pulse", 64'(timeout_pulse), 64'd1);
        tick(); tick();
        force_data = 32'h0bad0bad; force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("late_no_ack", 64'(m_reg_ack), 64'd0);
            check("late_data_kept", 64'(m_reg_rd_data), 64'(DEAD));
            tick();
        end
        m_reg_req[0] = 1'b0;
        tick(); tick();

        // Contention after reset: grants alternate starting with master 0.
        reset = 1'b1; tick(); reset = 1'b0;
        slv_lat = 1;
        set_m(0, 1'b1, 18'h00040, 32'h0);
        set_m(1, 1'b1, 18'h00080, 32'h0);
        m_reg_req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_ack(who, cyc);
            check("cont_order", 64'(who), 64'(k % 2));
            if (who >= 0) begin
                m_reg_req[who] = 1'b0;
                tick();
                check("cont_single", 64'(m_reg_ack), 64'd0);
                m_reg_req[who] = 1'b1;
            end
        end
        m_reg_req = '0;
        tick(); tick(); tick();

        // Held request: master 0 keeps req after ack; master 1 must wait.
        m_reg_req[0] = 1'b1;
        wait_ack(who, cyc);
        check("held_first", 64'(who), 64'd0);
        m_reg_req[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("held_quiet", 64'({m_reg_ack, s_reg_req}), 64'd0);
        end
        m_reg_req[0] = 1'b0;
        wait_ack(who, cyc);
        check("held_next_who", 64'(who), 64'd1);
        check("held_next_latency", 64'(cyc), 64'd4);
        finish_txn(1);

        // Reset in GRANT after master 0 was granted; master 0 must win again.
        slv_lat = 0;
        m_reg_req[0] = 1'b1;
        tick(); tick(); tick(); tick();
        check("rg_in_grant", 64'(s_reg_req), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rg_s_req", 64'(s_reg_req), 64'd0);
        check("rg_ack_to", 64'({m_reg_ack, timeout_pulse}), 64'd0);
        check("rg_rd_data", 64'(m_reg_rd_data), 64'd0);
        slv_lat = 1;
        m_reg_req = 2'b11;
        wait_ack(who, cyc);
        check("rg_winner", 64'(who), 64'd0);
        m_reg_req = '0;
        tick(); tick(); tick();

        // Randomized traffic against the transaction-level model.
        reset = 1'b1; tick(); reset = 1'b0;
        mdl_last = N - 1;
        for (int it = 0; it < 40; it++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            lat  = $urandom_range(0, 20);
            slv_lat = lat;
            for (int i = 0; i < N; i++) begin
                rrw[i] = 1'($urandom);
                ra[i]  = AW'($urandom);
                rd[i]  = $urandom;
                set_m(i, rrw[i], ra[i], rd[i]);
            end
            exp_w   = rr_pick(mask, mdl_last);
            exp_cyc = (lat >= 1 && lat <= TO - 1) ? lat + 2 : TO + 1;
            m_reg_req = mask;
            wait_ack(who, cyc);
            check("rnd_winner", 64'(who), 64'(exp_w));
            check("rnd_latency", 64'(cyc), 64'(exp_cyc));
            check("rnd_timeout", 64'(timeout_pulse), 64'(exp_cyc == TO + 1 ? 1 : 0));
            check("rnd_rd_data", 64'(m_reg_rd_data), 64'(exp_cyc == TO + 1 ? DEAD : rd_fn(ra[exp_w])));
            check("rnd_s_fields", 64'({cap_addr, cap_rw, cap_wd}), 64'({ra[exp_w], rrw[exp_w], rd[exp_w]}));
            mdl_last = exp_w;
            m_reg_req = '0;
            tick();
            check("rnd_single", 64'(m_reg_ack), 64'd0);
            tick(); tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_master_arbiter.md
Name: reg_master_arbiter

Overview:
- Shares one core register slave port (req/ack/rd_wr_L handshake) between NUM_MASTERS requesters, e.g. PCI register access and an on-chip config sequencer.
- Arbitration is round-robin, one transaction at a time.
- Per-transaction timeout: a slave that never acks cannot hang the bus; the master is answered with 0xdeadbeef.
- Sits between the requesters and the core register decoder/leaf blocks.

Parameters:
- NUM_MASTERS, 2: number of requesters (2..8).
- ADDR_WIDTH, 18: register word-address width.
- DATA_WIDTH, 32: register data width.
- TIMEOUT, 16: cycles waited for s_reg_ack after s_reg_req rises (1..255).

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- m_reg_req  in  NUM_MASTERS  per-master request; held high until m_reg_ack, then dropped.
- m_reg_rd_wr_L  in  NUM_MASTERS  1=read, 0=write.
- m_reg_addr  in  NUM_MASTERS*ADDR_WIDTH  flattened; master i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- m_reg_wr_data  in  NUM_MASTERS*DATA_WIDTH  flattened, same packing.
- m_reg_ack  out  NUM_MASTERS  one-cycle ack pulse to the granted master.
- m_reg_rd_data  out  DATA_WIDTH  read data shared by all masters; valid with m_reg_ack.
- s_reg_req  out  1  request to slave.
- s_reg_rd_wr_L  out  1  to slave.
- s_reg_addr  out  ADDR_WIDTH  to slave.
- s_reg_wr_data  out  DATA_WIDTH  to slave.
- s_reg_ack  in  1  slave ack pulse.
- s_reg_rd_data  in  DATA_WIDTH  slave read data; valid with s_reg_ack.
- timeout_pulse  out  1  one-cycle pulse per timed-out transaction.

Behaviour:
- Reset values:
  - all outputs 0.
  - state=IDLE, last_grant=NUM_MASTERS-1 (master 0 wins first), timer=0.
- All outputs are registered.
- State IDLE:
  - If any m_reg_req bit is set, pick the first requester scanning last_grant+1, last_grant+2, … modulo NUM_MASTERS.
  - Latch grant index, rd_wr_L, addr and wr_data into the s_reg_* registers; set s_reg_req=1 next cycle; set last_grant=grant; go to GRANT.
- State GRANT:
  - s_reg_req held at 1; s_reg_* fields stable; timer increments each cycle.
  - On s_reg_ack=1: register s_reg_rd_data into m_reg_rd_data; pulse m_reg_ack[grant] next cycle; s_reg_req=0 next cycle; go to DROP.
  - Else, if timer==TIMEOUT-1: m_reg_rd_data=0xdeadbeef (low DATA_WIDTH bits); pulse m_reg_ack[grant] and timeout_pulse; s_reg_req=0; go to DROP.
  - If ack and timeout occur in the same cycle, the ack wins and no timeout_pulse is issued.
- State DROP:
  - Wait until m_reg_req[grant]==0 and s_reg_ack==0, then go to IDLE and clear timer.
  - m_reg_ack is low here (single pulse only).
  - A slave ack arriving in DROP (late ack after a timeout) is ignored; its data does not overwrite m_reg_rd_data.
- Minimum latency from m_reg_req rise to m_reg_ack: 3 cycles with a slave acking 1 cycle after s_reg_req.
- m_reg_rd_data holds its last value until the next ack. It is undefined for write transactions but still driven from s_reg_rd_data.
- Requests from non-granted masters are ignored until IDLE; they are not queued beyond their held req level.
- A master dropping its req before ack while in GRANT: the transaction completes anyway; the ack pulse is still issued; DROP exits immediately.
- Reset mid-transaction: immediate return to IDLE, all outputs 0; the slave sees s_reg_req fall.
- NUM_MASTERS=1 degenerates to pass-through with timeout.

Test Plan:
- Single read: master0 req, addr 0x00010, slave acks 1 cycle after s_reg_req with 0x12345678 -> s_reg_addr=0x00010; m_reg_ack[0] pulses once, 3 cycles after req; m_reg_rd_data=0x12345678.
- Contention: masters 0 and 1 request together, both re-request continuously -> grants alternate 0,1,0,1; each ack is a single pulse; no overlapping s_reg_req transactions.
- Write: master1 write addr 0x3ffff, data 0xa5a5a5a5 -> s_reg_rd_wr_L=0, s_reg_addr=0x3ffff, s_reg_wr_data=0xa5a5a5a5 stable for the whole of GRANT.
- Timeout: slave never acks, TIMEOUT=16:
  - m_reg_ack pulses 16 cycles after s_reg_req rises, with rd_data=0xdeadbeef and timeout_pulse=1.
  - A late slave ack then arrives 2 cycles later -> m_reg_rd_data stays 0xdeadbeef, no extra m_reg_ack.
- Held request: master keeps req high 5 cycles after ack -> no second ack; arbiter stays in DROP until req falls, then next request is served.
- Reset in GRANT: assert reset for 1 cycle -> s_reg_req, m_reg_ack, timeout_pulse=0 next cycle; the next request from master0 wins (last_grant reset).
